// File: rtl/cpu_types_pkg.sv
// rtl/cpu_types_pkg.sv - shared CPU/memory types and constants for the RAM interface
package cpu_types_pkg;

    typedef logic [31:0] word_t;

    typedef enum logic [1:0] {
        FREE   = 2'd0,
        BUSY   = 2'd1,
        ACCESS = 2'd2,
        ERROR  = 2'd3
    } ramstate_t;

    localparam word_t RAM_ERR_WORD = 32'hBAD1BAD1;
    localparam int    RAM_CNT_W    = $clog2(16);

endpackage

// File: rtl/ram_array.sv
// rtl/ram_array.sv - word storage with prioritized dual write, registered and combinational reads
module ram_array
    import cpu_types_pkg::*;
#(
    parameter int DEPTH = 1024,
    parameter int IDX_W = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             req_we,
    input  logic [IDX_W-1:0] req_idx,
    input  word_t            req_wdata,
    input  logic             rd_en,
    input  logic             rd_force,
    input  word_t            rd_force_data,
    output word_t            rd_q,
    input  logic             tb_we,
    input  logic [IDX_W-1:0] tb_idx,
    input  word_t            tb_wdata,
    output word_t            tb_rdata
);

    word_t mem_q [DEPTH];
    word_t rd_d;

    always_comb begin
        rd_d = rd_q;
        if (!resetn) begin
            rd_d = '0;
        end else if (rd_en) begin
            rd_d = mem_q[req_idx];
        end else if (rd_force) begin
            rd_d = rd_force_data;
        end
    end

    // Storage is deliberately outside reset; the tb write is issued last so it wins on a collision.
    always_ff @(posedge clk) begin
        rd_q <= rd_d;
        if (req_we) begin
            mem_q[req_idx] <= req_wdata;
        end
        if (tb_we) begin
            mem_q[tb_idx] <= tb_wdata;
        end
    end

    assign tb_rdata = mem_q[tb_idx];

endmodule

// File: rtl/ram_responder.sv
// rtl/ram_responder.sv - RAM request responder: FSM with programmable latency over ram_array
module ram_responder
    import cpu_types_pkg::*;
#(
    parameter int LAT   = 2,
    parameter int DEPTH = 1024
) (
    input  logic      CLK,
    input  logic      nRST,
    input  logic      ramREN,
    input  logic      ramWEN,
    input  word_t     ramaddr,
    input  word_t     ramstore,
    output word_t     ramload,
    output ramstate_t ramstate,
    input  logic      tbWEN,
    input  word_t     tbaddr,
    input  word_t     tbdata,
    output word_t     tbload
);

    localparam int IDX_W = $clog2(DEPTH);
    localparam logic [RAM_CNT_W-1:0] CNT_RELOAD = (LAT > 0) ? RAM_CNT_W'(LAT - 1) : '0;

    ramstate_t              state_q, state_d;
    logic [RAM_CNT_W-1:0]   cnt_q, cnt_d;
    logic                   lat_we_q, lat_we_d;
    word_t                  lat_addr_q, lat_addr_d;
    word_t                  lat_data_q, lat_data_d;

    logic req, bad, changed, do_acc, force_err;
    logic [IDX_W+1:0] unused_tb_bits;

    assign req     = ramREN | ramWEN;
    assign bad     = (ramREN & ramWEN) | (ramaddr[1:0] != 2'b00)
                   | ({2'b00, ramaddr[31:2]} >= 32'(DEPTH));
    assign changed = (ramWEN != lat_we_q) | (ramaddr != lat_addr_q) | (ramstore != lat_data_q);
    assign unused_tb_bits = {tbaddr[31:IDX_W+2], tbaddr[1:0]};

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        lat_we_d   = lat_we_q;
        lat_addr_d = lat_addr_q;
        lat_data_d = lat_data_q;
        do_acc     = 1'b0;
        force_err  = 1'b0;
        case (state_q)
            FREE: begin
                if (req) begin
                    if (bad) begin
                        state_d   = ERROR;
                        force_err = 1'b1;
                    end else if (LAT > 0) begin
                        state_d    = BUSY;
                        cnt_d      = CNT_RELOAD;
                        lat_we_d   = ramWEN;
                        lat_addr_d = ramaddr;
                        lat_data_d = ramstore;
                    end else begin
                        state_d = ACCESS;
                        do_acc  = 1'b1;
                    end
                end
            end
            BUSY: begin
                if (!req) begin
                    state_d = FREE;
                end else if (bad) begin
                    state_d   = ERROR;
                    force_err = 1'b1;
                end else if (changed) begin
                    cnt_d      = CNT_RELOAD;
                    lat_we_d   = ramWEN;
                    lat_addr_d = ramaddr;
                    lat_data_d = ramstore;
                end else if (cnt_q == '0) begin
                    state_d = ACCESS;
                    do_acc  = 1'b1;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            ACCESS: state_d = FREE;
            ERROR: begin
                if (!(req && bad)) begin
                    state_d = FREE;
                end
            end
            default: state_d = FREE;
        endcase
        // Reset abandons any in-flight request, including a write about to commit.
        if (!nRST) begin
            state_d    = FREE;
            cnt_d      = '0;
            lat_we_d   = 1'b0;
            lat_addr_d = '0;
            lat_data_d = '0;
            do_acc     = 1'b0;
            force_err  = 1'b0;
        end
    end

    always_ff @(posedge CLK) begin
        state_q    <= state_d;
        cnt_q      <= cnt_d;
        lat_we_q   <= lat_we_d;
        lat_addr_q <= lat_addr_d;
        lat_data_q <= lat_data_d;
    end

    ram_array #(.DEPTH(DEPTH), .IDX_W(IDX_W)) u_array (
        .clk           (CLK),
        .resetn        (nRST),
        .req_we        (do_acc & ramWEN),
        .req_idx       (ramaddr[IDX_W+1:2]),
        .req_wdata     (ramstore),
        .rd_en         (do_acc & ramREN),
        .rd_force      (force_err),
        .rd_force_data (RAM_ERR_WORD),
        .rd_q          (ramload),
        .tb_we         (tbWEN),
        .tb_idx        (tbaddr[IDX_W+1:2]),
        .tb_wdata      (tbdata),
        .tb_rdata      (tbload)
    );

    assign ramstate = state_q;

endmodule

// File: tb/tb_ram_responder.sv
// tb/tb_ram_responder.sv - self-checking bench for ram_responder (LAT=2 and LAT=0 instances)
module tb_ram_responder;
    import cpu_types_pkg::*;

    localparam int LAT   = 2;
    localparam int DEPTH = 64;

    logic      CLK = 1'b0;
    logic      nRST;
    logic      ramREN, ramWEN, tbWEN;
    word_t     ramaddr, ramstore, tbaddr, tbdata, ramload, tbload;
    ramstate_t ramstate;

    logic      z_REN, z_WEN, z_tbWEN;
    word_t     z_addr, z_store, z_tbaddr, z_tbdata, z_load, z_tbload;
    ramstate_t z_state;

    int n_chk  = 0;
    int n_fail = 0;

    word_t ref_mem [DEPTH];
    word_t model_load;

    typedef struct {
        logic      ren;
        logic      wen;
        word_t     addr;
        word_t     data;
        ramstate_t exp_st;
        int        exp_cyc;
        logic      chk_load;
        word_t     exp_load;
        word_t     exp_tbl;
    } vec_t;

    vec_t vecs [8];

    always #5 CLK = ~CLK;

    ram_responder #(.LAT(LAT), .DEPTH(DEPTH)) dut (
        .CLK(CLK), .nRST(nRST), .ramREN(ramREN), .ramWEN(ramWEN), .ramaddr(ramaddr),
        .ramstore(ramstore), .ramload(ramload), .ramstate(ramstate), .tbWEN(tbWEN),
        .tbaddr(tbaddr), .tbdata(tbdata), .tbload(tbload)
    );

    ram_responder #(.LAT(0), .DEPTH(DEPTH)) dut0 (
        .CLK(CLK), .nRST(nRST), .ramREN(z_REN), .ramWEN(z_WEN), .ramaddr(z_addr),
        .ramstore(z_store), .ramload(z_load), .ramstate(z_state), .tbWEN(z_tbWEN),
        .tbaddr(z_tbaddr), .tbdata(z_tbdata), .tbload(z_tbload)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic tb_write(input word_t a, input word_t d);
        tbWEN = 1'b1; tbaddr = a; tbdata = d;
        step();
        tbWEN = 1'b0;
        ref_mem[(a >> 2) % DEPTH] = d;
    endtask

    task automatic run_txn(input logic ren, input logic wen, input word_t a, input word_t d,
                           output int cyc, output ramstate_t st, output word_t ld, output word_t tbl);
        ramREN = ren; ramWEN = wen; ramaddr = a; ramstore = d; tbaddr = a;
        cyc = 0;
        do begin
            step();
            cyc++;
        end while ((ramstate == FREE || ramstate == BUSY) && cyc < 40);
        st  = ramstate;
        ld  = ramload;
        tbl = tbload;
        ramREN = 1'b0; ramWEN = 1'b0;
        step();
        chk("return_to_free", ramstate, FREE);
    endtask

    // Reference behaviour from the request's point of view: a good request costs LAT+1 cycles
    // to ACCESS, a bad one goes straight to ERROR and leaves the array alone.
    task automatic model_txn(input logic ren, input logic wen, input word_t a, input word_t d,
                             output ramstate_t st, output int cyc, output word_t ld, output word_t tbl);
        int unsigned widx;
        logic is_bad;
        widx   = a >> 2;
        is_bad = (ren && wen) || (a % 4 != 0) || (widx >= DEPTH);
        if (is_bad) begin
            st = ERROR; cyc = 1; model_load = RAM_ERR_WORD;
        end else begin
            st = ACCESS; cyc = LAT + 1;
            if (wen) ref_mem[widx] = d;
            else     model_load = ref_mem[widx];
        end
        ld  = model_load;
        tbl = ref_mem[widx % DEPTH];
    endtask

    initial begin
        int        cyc, e_cyc;
        ramstate_t st, e_st;
        word_t     ld, e_ld, tbl, e_tbl, a, d;

        vecs[0] = '{1'b1, 1'b0, 32'h40,  32'h0,        ACCESS, 3, 1'b1, 32'hDEADBEEF, 32'hDEADBEEF};
        vecs[1] = '{1'b0, 1'b1, 32'h80,  32'h12345678, ACCESS, 3, 1'b1, 32'hDEADBEEF, 32'h12345678};
        vecs[2] = '{1'b1, 1'b0, 32'h80,  32'h0,        ACCESS, 3, 1'b1, 32'h12345678, 32'h12345678};
        vecs[3] = '{1'b1, 1'b1, 32'h40,  32'h55555555, ERROR,  1, 1'b1, 32'hBAD1BAD1, 32'hDEADBEEF};
        vecs[4] = '{1'b1, 1'b0, 32'h42,  32'h0,        ERROR,  1, 1'b1, 32'hBAD1BAD1, 32'hDEADBEEF};
        vecs[5] = '{1'b1, 1'b0, 32'h100, 32'h0,        ERROR,  1, 1'b1, 32'hBAD1BAD1, 32'h00C0FFEE};
        vecs[6] = '{1'b0, 1'b1, 32'h46,  32'hFFFFFFFF, ERROR,  1, 1'b1, 32'hBAD1BAD1, 32'hCAFEF00D};
        vecs[7] = '{1'b1, 1'b0, 32'h44,  32'h0,        ACCESS, 3, 1'b1, 32'hCAFEF00D, 32'hCAFEF00D};

        nRST = 1'b0; ramREN = 1'b0; ramWEN = 1'b0; ramaddr = '0; ramstore = '0;
        tbWEN = 1'b0; tbaddr = '0; tbdata = '0;
        z_REN = 1'b0; z_WEN = 1'b0; z_addr = '0; z_store = '0;
        z_tbWEN = 1'b0; z_tbaddr = '0; z_tbdata = '0;
        repeat (3) step();
        chk("reset_state", ramstate, FREE);
        chk("reset_load", ramload, 32'h0);
        chk("reset_state_lat0", z_state, FREE);
        chk("reset_load_lat0", z_load, 32'h0);
        nRST = 1'b1;
        model_load = '0;

        for (int i = 0; i < DEPTH; i++) tb_write(32'(i * 4), $urandom);
        tb_write(32'h0, 32'h00C0FFEE);
        tb_write(32'h40, 32'hDEADBEEF);
        tb_write(32'h44, 32'hCAFEF00D);

        // Read 0x40 held: BUSY, BUSY, ACCESS, FREE
        ramREN = 1'b1; ramaddr = 32'h40;
        step(); chk("seq_busy1", ramstate, BUSY);
        step(); chk("seq_busy2", ramstate, BUSY);
        step(); chk("seq_access", ramstate, ACCESS);
        chk("seq_load", ramload, 32'hDEADBEEF);
        ramREN = 1'b0;
        step(); chk("seq_free", ramstate, FREE);
        model_load = 32'hDEADBEEF;

        for (int i = 0; i < 8; i++) begin
            run_txn(vecs[i].ren, vecs[i].wen, vecs[i].addr, vecs[i].data, cyc, st, ld, tbl);
            model_txn(vecs[i].ren, vecs[i].wen, vecs[i].addr, vecs[i].data, e_st, e_cyc, e_ld, e_tbl);
            chk($sformatf("vec%0d_state", i), st, vecs[i].exp_st);
            chk($sformatf("vec%0d_cycles", i), cyc, vecs[i].exp_cyc);
            if (vecs[i].chk_load) chk($sformatf("vec%0d_load", i), ld, vecs[i].exp_load);
            chk($sformatf("vec%0d_tbload", i), tbl, vecs[i].exp_tbl);
        end

        // Address change after one BUSY cycle restarts the latency count
        ramREN = 1'b1; ramaddr = 32'h40;
        step(); step();
        ramaddr = 32'h44;
        step(); chk("restart_busy_a", ramstate, BUSY);
        step(); chk("restart_busy_b", ramstate, BUSY);
        step(); chk("restart_access", ramstate, ACCESS);
        chk("restart_load", ramload, 32'hCAFEF00D);
        ramREN = 1'b0;
        step();
        model_load = 32'hCAFEF00D;

        // Reset on the edge that would commit a write
        ramWEN = 1'b1; ramaddr = 32'h88; ramstore = 32'hA5A5A5A5; tbaddr = 32'h88;
        step(); step();
        nRST = 1'b0;
        step();
        chk("rst_write_state", ramstate, FREE);
        chk("rst_write_mem", tbload, ref_mem[32'h88 >> 2]);
        chk("rst_write_load", ramload, 32'h0);
        ramWEN = 1'b0; nRST = 1'b1;
        model_load = '0;
        run_txn(1'b1, 1'b0, 32'h80, 32'h0, cyc, st, ld, tbl);
        chk("post_reset_read", ld, 32'h12345678);
        model_load = ld;

        // LAT=0: 2-cycle throughput
        z_tbWEN = 1'b1; z_tbaddr = 32'h10; z_tbdata = 32'h11112222;
        step();
        z_tbaddr = 32'h14; z_tbdata = 32'h33334444;
        step();
        z_tbWEN = 1'b0;
        z_REN = 1'b1; z_addr = 32'h10;
        step(); chk("lat0_access1", z_state, ACCESS);
        chk("lat0_load1", z_load, 32'h11112222);
        z_addr = 32'h14;
        step(); chk("lat0_free", z_state, FREE);
        step(); chk("lat0_access2", z_state, ACCESS);
        chk("lat0_load2", z_load, 32'h33334444);
        z_REN = 1'b0;
        step(); chk("lat0_idle", z_state, FREE);

        // Randomized transactions against the reference model
        for (int n = 0; n < 60; n++) begin
            int unsigned kind, idx;
            logic ren, wen;
            if ($urandom_range(0, 2) == 0) tb_write(32'($urandom_range(0, DEPTH - 1) * 4), $urandom);
            kind = $urandom_range(0, 9);
            idx  = $urandom_range(0, DEPTH - 1);
            d    = $urandom;
            a    = 32'(idx * 4);
            ren  = (kind < 4) || (kind == 8);
            wen  = (kind >= 4 && kind < 8) || (kind == 8);
            if (kind == 9) begin
                ren = 1'b1;
                if ($urandom_range(0, 1) == 0) a = a + 32'($urandom_range(1, 3));
                else                            a = 32'(($urandom_range(DEPTH, 4 * DEPTH)) * 4);
            end
            run_txn(ren, wen, a, d, cyc, st, ld, tbl);
            model_txn(ren, wen, a, d, e_st, e_cyc, e_ld, e_tbl);
            chk($sformatf("rnd%0d_state", n), st, e_st);
            chk($sformatf("rnd%0d_cycles", n), cyc, e_cyc);
            chk($sformatf("rnd%0d_load", n), ld, e_ld);
            chk($sformatf("rnd%0d_tbload", n), tbl, e_tbl);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
